retire_trace_buf: RTL and testbench
===================================

// Module: retire_trace_buf
// PURPOSE
//  Consumer end of the hart retire interface: captures each retired instruction record into a FIFO.
//  Drains the records to the testbench/debug host over a valid/ready stream.
//  Tracks retired and dropped counts and the halt/done status.
//  Sits beside the hart and samples its o_retire_* outputs every cycle. The hart cannot be stalled.
// PARAMETERS
//  DEPTH  16  record slots; power of 2, >=2
//  AW     $clog2(DEPTH)  pointer width (derived, not overridden)
// PORTS
//  i_clk              in   1   single clock, rising edge
//  i_rst_n            in   1   asynchronous, active-low reset
//  i_retire_valid     in   1   retire strobe from hart
//  i_retire_pc        in   32  PC of retiring instruction
//  i_retire_next_pc   in   32  next PC of retiring instruction
//  i_retire_inst      in   32  instruction word
//  i_retire_rd_waddr  in   5   destination register (0 = none)
//  i_retire_rd_wdata  in   32  destination data
//  i_retire_trap      in   1   trap flag
//  i_retire_halt      in   1   ebreak flag
//  o_trace_valid      out  1   head record available
//  i_trace_ready      in   1   consumer accepts head record
//  o_trace_pc/_inst/_rd_waddr/_rd_wdata/_trap/_halt  out  32/32/5/32/1/1  head record fields
//  o_count            out  AW+1  records held, 0..DEPTH
//  o_full / o_empty   out  1   count==DEPTH / count==0
//  o_overflow         out  1   sticky: at least one record dropped
//  o_drop_cnt         out  16  dropped records, saturates at 16'hFFFF
//  o_retired_cnt      out  32  valid retires seen in RUN, wraps mod 2^32
//  o_halted           out  1   state != RUN
//  o_done             out  1   state == DONE
// BEHAVIOUR
//  Reset (i_rst_n=0, async): pointers, count, all counters and sticky flags clear; state=RUN; every output is 0.
//  push = i_retire_valid & state==RUN & (!o_full | pop); pop = o_trace_valid & i_trace_ready.
//  o_trace_valid = !o_empty.
//  Record fields are 0 when o_trace_valid=0.
//  Latency: a pushed record is visible at the head on the next edge, when the FIFO was empty.
//  Full with simultaneous pop: push is accepted, count stays DEPTH, no drop.
//  Empty with i_trace_ready=1: no pop, pointers unchanged.
//  Drop = i_retire_valid & state==RUN & o_full & !pop. On a drop:
//    o_drop_cnt increments, saturating at 16'hFFFF;
//    o_overflow sets;
//    the record is discarded.
//  o_retired_cnt increments on every i_retire_valid in RUN, whether the record is pushed or dropped.
//  Pointers are AW bits and wrap DEPTH-1 -> 0.
//  count is updated as count + push - pop.
//  FSM states:
//    RUN    -> HALTED on i_retire_valid & i_retire_halt (the halt record is pushed or dropped as above);
//    HALTED -> DONE when o_empty (evaluated the cycle after halt at the earliest);
//    HALTED: retires are ignored; they are not counted, pushed or dropped.
//    DONE is terminal until reset; pops remain legal but the FIFO is empty.
//  Reset asserted mid-stream discards all buffered records immediately.
// CONFIGURATION
//  RETIRE_TRACE_PC_CHECK_EN defined: adds the PC continuity check with these outputs:
//    o_pc_mismatch    out  1   sticky flag
//    o_mismatch_pc    out  32  offending i_retire_pc, captured on the first mismatch only
//    Internal exp_pc/have_prev track the check. Each RUN retire loads exp_pc=i_retire_next_pc and have_prev=1.
//    Mismatch = have_prev & i_retire_pc != exp_pc; it is checked for dropped records too.
//  RETIRE_TRACE_PC_CHECK_EN undefined: no check logic; o_pc_mismatch and o_mismatch_pc are tied to 0.
// STRUCTURE
//  Package retire_trace_pkg:
//    retire_rec_t struct {pc, inst, rd_waddr, rd_wdata, trap, halt} (103 bits);
//    state enum {RUN, HALTED, DONE};
//    DROP_CNT_W=16.
//  Sub-module sync_fifo #(WIDTH, DEPTH): storage, pointers, count, full/empty, push/pop.
//  Top level: push/drop qualification, counters, FSM, optional check.
// TESTING
//  1. Reset, then 3 retires at pc 0x0/0x4/0x8 with ready=0
//     -> o_count=3, head pc=0x0; raise ready -> pcs 0x0,0x4,0x8 drain in order, then o_empty=1.
//  2. DEPTH=16, ready=0, 20 consecutive retires
//     -> o_full=1, o_drop_cnt=4, o_overflow=1, o_retired_cnt=20; drained pcs are the first 16.
//  3. Full FIFO, retire and ready in the same cycle
//     -> no drop, o_count stays 16, new record at tail.
//  4. Retire with halt=1 at pc 0x40, then 2 more retires
//     -> o_halted=1, o_retired_cnt excludes the extra 2; after drain o_done=1.
//  5. Assert i_rst_n=0 mid-stream with 5 records buffered
//     -> o_count=0, o_trace_valid=0 and counters 0 with no clock edge.
//  6. With RETIRE_TRACE_PC_CHECK_EN: retire pc 0x0 next_pc 0x4, then pc 0x10
//     -> o_pc_mismatch=1, o_mismatch_pc=0x10.
//     Without the macro -> both outputs stay 0.

Source files
------------

// File: rtl/retire_trace_pkg.sv
// Shared types for the retire trace buffer: the retire record payload,
// the capture FSM state encoding and counter widths.
package retire_trace_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned DROP_CNT_W = 16;

    // One retired instruction as captured from the hart (103 bits).
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   inst;
        logic [REG_AW-1:0] rd_waddr;
        logic [XLEN-1:0]   rd_wdata;
        logic              trap;
        logic              halt;
    } retire_rec_t;

    localparam int unsigned REC_W = $bits(retire_rec_t);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/retire_trace_buf_sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   push_i / wdata_i        write request and data (accepted if not full or popping)
//   pop_i                   read request (ignored when empty)
//   rdata_o                 head entry, zero when empty
//   count_o, full_o, empty_o occupancy status
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [AW:0]      count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    // When full, a same-cycle pop frees the slot being written.
    assign push_ok = push_i & (~full_o | pop_ok);

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; contents are only visible through count.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign count_o = count_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/retire_trace_buf.sv
// retire_trace_buf: captures hart retire records into a FIFO and drains them
// over a valid/ready stream; tracks retired/dropped counts and halt status.
// Optional feature macro: RETIRE_TRACE_PC_CHECK_EN (PC continuity check).
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_retire_*              retire record sampled every cycle (hart cannot stall)
//   o_trace_*, i_trace_ready head record stream
//   o_count/o_full/o_empty  FIFO occupancy
//   o_overflow/o_drop_cnt   dropped-record status
//   o_retired_cnt           retires seen while running
//   o_halted/o_done         FSM status
//   o_pc_mismatch/o_mismatch_pc PC continuity result (zero when check not built)
module retire_trace_buf
    import retire_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_retire_valid,
    input  logic [31:0]           i_retire_pc,
    input  logic [31:0]           i_retire_next_pc,
    input  logic [31:0]           i_retire_inst,
    input  logic [4:0]            i_retire_rd_waddr,
    input  logic [31:0]           i_retire_rd_wdata,
    input  logic                  i_retire_trap,
    input  logic                  i_retire_halt,
    output logic                  o_trace_valid,
    input  logic                  i_trace_ready,
    output logic [31:0]           o_trace_pc,
    output logic [31:0]           o_trace_inst,
    output logic [4:0]            o_trace_rd_waddr,
    output logic [31:0]           o_trace_rd_wdata,
    output logic                  o_trace_trap,
    output logic                  o_trace_halt,
    output logic [AW:0]           o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_overflow,
    output logic [DROP_CNT_W-1:0] o_drop_cnt,
    output logic [31:0]           o_retired_cnt,
    output logic                  o_halted,
    output logic                  o_done,
    output logic                  o_pc_mismatch,
    output logic [31:0]           o_mismatch_pc
);

    state_e                state_q, state_d;
    retire_rec_t           wr_rec;
    retire_rec_t           rd_rec;
    logic [AW:0]           fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  run_retire;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [31:0]           retired_cnt_q, retired_cnt_d;

    // Retires only count while running; halted retires are ignored entirely.
    assign run_retire = i_retire_valid & (state_q == RUN);
    assign pop        = ~fifo_empty & i_trace_ready;
    assign push       = run_retire & (~fifo_full | pop);
    assign drop       = run_retire & fifo_full & ~pop;

    assign wr_rec = '{pc:       i_retire_pc,
                      inst:     i_retire_inst,
                      rd_waddr: i_retire_rd_waddr,
                      rd_wdata: i_retire_rd_wdata,
                      trap:     i_retire_trap,
                      halt:     i_retire_halt};

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_rec),
        .rdata_o (rd_rec),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next state: halt record moves to HALTED, then DONE once drained.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (run_retire & i_retire_halt) state_d = HALTED;
            HALTED:  if (fifo_empty) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= RUN;
        else          state_q <= state_d;
    end

    // Retire and drop accounting; drop count saturates at all-ones.
    always_comb begin
        overflow_d    = overflow_q;
        drop_cnt_d    = drop_cnt_q;
        retired_cnt_d = retired_cnt_q;
        if (run_retire) retired_cnt_d = retired_cnt_q + 32'd1;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
            retired_cnt_q <= '0;
        end else begin
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

`ifdef RETIRE_TRACE_PC_CHECK_EN
    logic [31:0] exp_pc_q, exp_pc_d;
    logic        have_prev_q, have_prev_d;
    logic        pc_mismatch_q, pc_mismatch_d;
    logic [31:0] mismatch_pc_q, mismatch_pc_d;
    logic        mismatch;

    // Checked on every running retire, including ones that get dropped.
    assign mismatch = run_retire & have_prev_q & (i_retire_pc != exp_pc_q);

    always_comb begin
        exp_pc_d      = exp_pc_q;
        have_prev_d   = have_prev_q;
        pc_mismatch_d = pc_mismatch_q | mismatch;
        mismatch_pc_d = mismatch_pc_q;
        if (run_retire) begin
            exp_pc_d    = i_retire_next_pc;
            have_prev_d = 1'b1;
        end
        if (mismatch & ~pc_mismatch_q) mismatch_pc_d = i_retire_pc;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            exp_pc_q      <= '0;
            have_prev_q   <= 1'b0;
            pc_mismatch_q <= 1'b0;
            mismatch_pc_q <= '0;
        end else begin
            exp_pc_q      <= exp_pc_d;
            have_prev_q   <= have_prev_d;
            pc_mismatch_q <= pc_mismatch_d;
            mismatch_pc_q <= mismatch_pc_d;
        end
    end

    assign o_pc_mismatch = pc_mismatch_q;
    assign o_mismatch_pc = mismatch_pc_q;
`else
    logic unused_next_pc;
    assign unused_next_pc = ^i_retire_next_pc;
    assign o_pc_mismatch  = 1'b0;
    assign o_mismatch_pc  = '0;
`endif

    assign o_trace_valid    = ~fifo_empty;
    assign o_trace_pc       = rd_rec.pc;
    assign o_trace_inst     = rd_rec.inst;
    assign o_trace_rd_waddr = rd_rec.rd_waddr;
    assign o_trace_rd_wdata = rd_rec.rd_wdata;
    assign o_trace_trap     = rd_rec.trap;
    assign o_trace_halt     = rd_rec.halt;
    assign o_count          = fifo_count;
    assign o_full           = fifo_full;
    // Held low while reset is asserted so every output reads zero in reset.
    assign o_empty          = fifo_empty & i_rst_n;
    assign o_overflow       = overflow_q;
    assign o_drop_cnt       = drop_cnt_q;
    assign o_retired_cnt    = retired_cnt_q;
    assign o_halted         = (state_q != RUN);
    assign o_done           = (state_q == DONE);

endmodule

// File: tb/tb_retire_trace_buf.sv
// Testbench for retire_trace_buf: directed scenarios plus random traffic,
// checked by a queue-based reference model and a negedge monitor.
module tb_retire_trace_buf;

    localparam int unsigned DEPTH = 16;
`ifdef RETIRE_TRACE_PC_CHECK_EN
    localparam bit PCCHK = 1'b1;
`else
    localparam bit PCCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_retire_valid = 1'b0;
    logic [31:0] i_retire_pc = '0;
    logic [31:0] i_retire_next_pc = '0;
    logic [31:0] i_retire_inst = '0;
    logic [4:0]  i_retire_rd_waddr = '0;
    logic [31:0] i_retire_rd_wdata = '0;
    logic        i_retire_trap = 1'b0;
    logic        i_retire_halt = 1'b0;
    logic        i_trace_ready = 1'b0;
    logic        o_trace_valid;
    logic [31:0] o_trace_pc, o_trace_inst, o_trace_rd_wdata;
    logic [4:0]  o_trace_rd_waddr;
    logic        o_trace_trap, o_trace_halt;
    logic [4:0]  o_count;
    logic        o_full, o_empty, o_overflow;
    logic [15:0] o_drop_cnt;
    logic [31:0] o_retired_cnt;
    logic        o_halted, o_done, o_pc_mismatch;
    logic [31:0] o_mismatch_pc;

    retire_trace_buf #(.DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_retire_valid(i_retire_valid), .i_retire_pc(i_retire_pc),
        .i_retire_next_pc(i_retire_next_pc), .i_retire_inst(i_retire_inst),
        .i_retire_rd_waddr(i_retire_rd_waddr), .i_retire_rd_wdata(i_retire_rd_wdata),
        .i_retire_trap(i_retire_trap), .i_retire_halt(i_retire_halt),
        .o_trace_valid(o_trace_valid), .i_trace_ready(i_trace_ready),
        .o_trace_pc(o_trace_pc), .o_trace_inst(o_trace_inst),
        .o_trace_rd_waddr(o_trace_rd_waddr), .o_trace_rd_wdata(o_trace_rd_wdata),
        .o_trace_trap(o_trace_trap), .o_trace_halt(o_trace_halt),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
        .o_overflow(o_overflow), .o_drop_cnt(o_drop_cnt),
        .o_retired_cnt(o_retired_cnt), .o_halted(o_halted), .o_done(o_done),
        .o_pc_mismatch(o_pc_mismatch), .o_mismatch_pc(o_mismatch_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        trap;
        logic        halt;
    } rec_t;

    // Reference model: expected FIFO contents and status.
    rec_t        sb[$];
    int          m_cnt;
    int          m_state;      // 0 running, 1 halted, 2 done
    int unsigned m_retired;
    int          m_drop;
    bit          m_over;
    bit          m_have;
    logic [31:0] m_exp;
    bit          m_mis;
    logic [31:0] m_mis_pc;

    int errors = 0;
    int checks = 0;
    logic [31:0] pc_cur = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_cnt = 0; m_state = 0; m_retired = 0; m_drop = 0; m_over = 0;
        m_have = 0; m_exp = '0; m_mis = 0; m_mis_pc = '0;
    endtask

    // One clock edge of the model, evaluated with the pre-edge inputs.
    task automatic model_step();
        bit pop, push;
        rec_t r;
        pop  = (m_cnt != 0) && i_trace_ready;
        push = 0;
        if (m_state == 0 && i_retire_valid) begin
            m_retired++;
            if (m_have && i_retire_pc != m_exp) begin
                if (!m_mis) m_mis_pc = i_retire_pc;
                m_mis = 1;
            end
            m_exp  = i_retire_next_pc;
            m_have = 1;
            if (m_cnt < DEPTH || pop) begin
                r = '{pc: i_retire_pc, inst: i_retire_inst, rd: i_retire_rd_waddr,
                      wd: i_retire_rd_wdata, trap: i_retire_trap, halt: i_retire_halt};
                sb.push_back(r);
                push = 1;
            end else begin
                m_over = 1;
                if (m_drop < 65535) m_drop++;
            end
            if (i_retire_halt) m_state = 1;
        end else if (m_state == 1 && m_cnt == 0) begin
            m_state = 2;
        end
        m_cnt = m_cnt + int'(push) - int'(pop);
    endtask

    // Monitor: status every cycle, head record whenever presented.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", 64'(o_count), 64'(m_cnt));
            chk("trace_valid", 64'(o_trace_valid), 64'(m_cnt != 0));
            chk("full", 64'(o_full), 64'(m_cnt == DEPTH));
            chk("empty", 64'(o_empty), 64'(m_cnt == 0));
            chk("overflow", 64'(o_overflow), 64'(m_over));
            chk("drop_cnt", 64'(o_drop_cnt), 64'(m_drop));
            chk("retired_cnt", 64'(o_retired_cnt), 64'(m_retired));
            chk("halted", 64'(o_halted), 64'(m_state != 0));
            chk("done", 64'(o_done), 64'(m_state == 2));
            chk("pc_mismatch", 64'(o_pc_mismatch), 64'(PCCHK & m_mis));
            chk("mismatch_pc", 64'(o_mismatch_pc), PCCHK ? 64'(m_mis_pc) : 64'd0);
            if (o_trace_valid) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sb_underflow: got valid record expected none at %0t", $time);
                end else begin
                    chk("head_pc", 64'(o_trace_pc), 64'(sb[0].pc));
                    chk("head_inst", 64'(o_trace_inst), 64'(sb[0].inst));
                    chk("head_rd", 64'(o_trace_rd_waddr), 64'(sb[0].rd));
                    chk("head_wdata", 64'(o_trace_rd_wdata), 64'(sb[0].wd));
                    chk("head_flags", 64'({o_trace_trap, o_trace_halt}),
                        64'({sb[0].trap, sb[0].halt}));
                    if (i_trace_ready) void'(sb.pop_front());
                end
            end else begin
                chk("idle_fields", 64'(o_trace_pc | o_trace_inst | o_trace_rd_wdata |
                    32'(o_trace_rd_waddr) | 32'(o_trace_trap) | 32'(o_trace_halt)), 64'd0);
            end
        end
    end

    task automatic cyc(input bit v, input logic [31:0] pc, input logic [31:0] npc,
                       input bit h, input bit rdy);
        i_retire_valid    = v;
        i_retire_pc       = pc;
        i_retire_next_pc  = npc;
        i_retire_inst     = $urandom;
        i_retire_rd_waddr = 5'($urandom);
        i_retire_rd_wdata = $urandom;
        i_retire_trap     = 1'($urandom_range(0, 1));
        i_retire_halt     = h;
        i_trace_ready     = rdy;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic ret(input bit rdy, input bit h);
        cyc(1'b1, pc_cur, pc_cur + 32'd4, h, rdy);
        pc_cur = pc_cur + 32'd4;
    endtask

    task automatic idle(input bit rdy);
        cyc(1'b0, pc_cur, pc_cur + 32'd4, 1'b0, rdy);
    endtask

    task automatic drain();
        int n = 0;
        while (m_cnt != 0 && n < 200) begin
            idle(1'b1);
            n++;
        end
        chk("drain_empty", 64'(o_empty), 64'd1);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        i_retire_valid = 1'b0;
        i_trace_ready  = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_valid", 64'(o_trace_valid), 64'd0);
        chk("rst_flags", 64'({o_full, o_empty, o_overflow, o_halted, o_done, o_pc_mismatch}), 64'd0);
        chk("rst_counters", 64'(o_drop_cnt) | 64'(o_retired_cnt) | 64'(o_mismatch_pc), 64'd0);
        chk("rst_fields", 64'(o_trace_pc | o_trace_inst), 64'd0);
        model_reset();
        pc_cur = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();

        // Three retires held, then drained in order.
        for (int i = 0; i < 3; i++) ret(1'b0, 1'b0);
        chk("t1_count", 64'(o_count), 64'd3);
        chk("t1_head_pc", 64'(o_trace_pc), 64'd0);
        drain();

        // Overfill: 20 retires into 16 slots.
        do_reset();
        for (int i = 0; i < 20; i++) ret(1'b0, 1'b0);
        chk("t2_full", 64'(o_full), 64'd1);
        chk("t2_drop_cnt", 64'(o_drop_cnt), 64'd4);
        chk("t2_overflow", 64'(o_overflow), 64'd1);
        chk("t2_retired", 64'(o_retired_cnt), 64'd20);

        // Full with simultaneous pop: accepted, no drop.
        ret(1'b1, 1'b0);
        chk("t3_count", 64'(o_count), 64'd16);
        chk("t3_drop_cnt", 64'(o_drop_cnt), 64'd4);
        drain();

        // Random traffic with bursts of back-pressure and PC jumps.
        do_reset();
        for (int i = 0; i < 800; i++) begin
            bit v, rdy;
            v   = ($urandom % 4) != 0;
            rdy = ((i % 100) < 30) ? 1'b0 : (($urandom % 3) != 0);
            if (v) begin
                if (($urandom % 16) == 0) pc_cur = $urandom & 32'hFFFF_FFFC;
                ret(rdy, 1'b0);
            end else begin
                idle(rdy);
            end
        end
        drain();

        // Halt record at 0x40, later retires ignored, then done.
        do_reset();
        pc_cur = 32'h40;
        ret(1'b0, 1'b1);
        ret(1'b0, 1'b0);
        ret(1'b0, 1'b0);
        chk("t4_halted", 64'(o_halted), 64'd1);
        chk("t4_retired", 64'(o_retired_cnt), 64'd1);
        chk("t4_count", 64'(o_count), 64'd1);
        drain();
        idle(1'b1);
        idle(1'b1);
        chk("t4_done", 64'(o_done), 64'd1);

        // Reset with five records buffered.
        do_reset();
        for (int i = 0; i < 5; i++) ret(1'b0, 1'b0);
        chk("t5_count", 64'(o_count), 64'd5);
        do_reset();

        // PC continuity: 0x0 -> next 0x4, then 0x10; second jump keeps first capture.
        cyc(1'b1, 32'h0, 32'h4, 1'b0, 1'b1);
        cyc(1'b1, 32'h10, 32'h14, 1'b0, 1'b1);
        chk("t6_mismatch", 64'(o_pc_mismatch), PCCHK ? 64'd1 : 64'd0);
        chk("t6_mismatch_pc", 64'(o_mismatch_pc), PCCHK ? 64'h10 : 64'd0);
        cyc(1'b1, 32'h100, 32'h104, 1'b0, 1'b1);
        chk("t6_mismatch_pc_hold", 64'(o_mismatch_pc), PCCHK ? 64'h10 : 64'd0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
